// File: rtl/rr_arbiter_4x1_pkg.sv
// Shared constants, slot state encoding and the rotating-priority search
// used by the 4-requester round-robin arbiter.
package rr_arbiter_4x1_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // Returns {found, index}: first set bit of req scanning upward from start
   // with wrap. When nothing is set the index is start itself.
   function automatic logic [SEL_W:0] rr_search(input logic [NUM_REQ-1:0] req,
                                                input logic [SEL_W-1:0]   start);
      logic [SEL_W-1:0] idx;
      logic             found;
      logic [SEL_W:0]   result;
      found  = 1'b0;
      result = {1'b0, start};
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = start + SEL_W'(k);
         if (!found && req[idx]) begin
            found  = 1'b1;
            result = {1'b1, idx};
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/rr_arbiter_4x1_mux.sv
// Parameterized 4:1 word multiplexer driven by the arbiter grant index.
module mux_4x1_param
   import rr_arbiter_4x1_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]     in0,
   input  logic [N-1:0]     in1,
   input  logic [N-1:0]     in2,
   input  logic [N-1:0]     in3,
   input  logic [SEL_W-1:0] sel,
   output logic [N-1:0]     out
);

   always_comb begin
      out = in0;
      case (sel)
         2'd1:    out = in1;
         2'd2:    out = in2;
         2'd3:    out = in3;
         default: out = in0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter_4x1.sv
// Round-robin arbiter merging four valid/ready requesters into one
// registered single-entry output slot.
module rr_arbiter_4x1
   import rr_arbiter_4x1_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] in_valid,
   input  logic [N-1:0]       in0,
   input  logic [N-1:0]       in1,
   input  logic [N-1:0]       in2,
   input  logic [N-1:0]       in3,
   output logic [NUM_REQ-1:0] in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N-1:0]       out_data,
   output logic [SEL_W-1:0]   out_src,
   output logic [SEL_W-1:0]   sel
);

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W:0]   search;
   logic             found;
   logic             free;
   logic             accept;
   logic [N-1:0]     mux_out;

   mux_4x1_param #(.N(N)) u_mux (
      .in0 (in0),
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .sel (sel),
      .out (mux_out)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_nxt;
   end

   // Grant and next-state are purely a function of in_valid, ptr, state and
   // out_ready; in_ready is forced low for the whole reset cycle.
   always_comb begin
      search    = rr_search(in_valid, ptr);
      found     = search[SEL_W];
      sel       = search[SEL_W-1:0];
      free      = (state == ST_EMPTY) || out_ready;
      accept    = 1'b0;
      in_ready  = '0;
      state_nxt = state;
      if (!rst && found && free) begin
         accept        = 1'b1;
         in_ready[sel] = 1'b1;
      end
      case (state)
         ST_EMPTY: if (accept) state_nxt = ST_FULL;
         ST_FULL: begin
            if (accept)         state_nxt = ST_FULL;
            else if (out_ready) state_nxt = ST_EMPTY;
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_src  <= '0;
         ptr      <= '0;
      end else if (accept) begin
         out_data <= mux_out;
         out_src  <= sel;
         ptr      <= sel + SEL_W'(1);
      end
   end

   assign out_valid = (state == ST_FULL);

endmodule

// File: tb/tb_rr_arbiter_4x1.sv
// Directed bench for rr_arbiter_4x1 with a cycle-level reference model and
// hand-computed expectations for the key scenarios.
module tb_rr_arbiter_4x1;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   in_valid;
   logic [N-1:0] in0, in1, in2, in3;
   logic [3:0]   in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic [1:0]   out_src;
   logic [1:0]   sel;

   int checks = 0;
   int errors = 0;

   rr_arbiter_4x1 #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in0       (in0),
      .in1       (in1),
      .in2       (in2),
      .in3       (in3),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_src   (out_src),
      .sel       (sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: ptr, slot occupancy and contents as plain integers.
   int           m_ptr  = 0;
   bit           m_full = 0;
   logic [N-1:0] m_data = '0;
   int           m_src  = 0;

   initial begin
      @(posedge clk);
      forever begin
         logic [N-1:0] words [4];
         int           g;
         int           j;
         logic [3:0]   e_ready;
         int           e_sel;
         @(negedge clk);
         words[0] = in0; words[1] = in1; words[2] = in2; words[3] = in3;
         g = -1;
         for (int k = 0; k < 4; k++) begin
            j = (m_ptr + k) % 4;
            if (g < 0 && in_valid[j]) g = j;
         end
         e_ready = 4'b0000;
         if (!rst && g >= 0 && (!m_full || out_ready)) e_ready[g] = 1'b1;
         e_sel = (g >= 0) ? g : m_ptr;
         chk("model_in_ready",  32'(in_ready),  32'(e_ready));
         chk("model_sel",       32'(sel),       32'(e_sel));
         chk("model_out_valid", 32'(out_valid), 32'(m_full));
         chk("model_out_data",  32'(out_data),  32'(m_data));
         chk("model_out_src",   32'(out_src),   32'(m_src));
         @(posedge clk);
         if (rst) begin
            m_ptr = 0; m_full = 0; m_data = '0; m_src = 0;
         end else if (e_ready != 4'b0000) begin
            m_full = 1; m_data = words[g]; m_src = g; m_ptr = (g + 1) % 4;
         end else if (m_full && out_ready) begin
            m_full = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] exp_d [4];
      bit           got3;
      exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC; exp_d[3] = 4'hD;

      // Reset with every requester active and the consumer ready.
      rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      in0 = 4'hA; in1 = 4'hB; in2 = 4'hC; in3 = 4'hD;
      step(); step();
      @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),  32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data",  32'(out_data),  32'h0);
      step();
      rst = 1'b0;

      // All four valid: strict rotation, one word per cycle.
      @(negedge clk);
      chk("rot_first_ready", 32'(in_ready), 32'b0001);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rot_src",   32'(out_src),   32'(i % 4));
         chk("rot_data",  32'(out_data),  32'(exp_d[i % 4]));
         chk("rot_valid", 32'(out_valid), 32'h1);
      end

      // Lone requester 2 is granted every cycle.
      in_valid = 4'b0100; in2 = 4'h5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lone_ready", 32'(in_ready), 32'b0100);
         step();
         chk("lone_data", 32'(out_data), 32'h5);
         chk("lone_src",  32'(out_src),  32'h2);
      end
      in_valid = 4'b0000;
      @(negedge clk);
      chk("lone_ptr3_sel", 32'(sel), 32'h3);
      step();
      chk("lone_drained", 32'(out_valid), 32'h0);
      in_valid = 4'b0100;
      @(negedge clk);
      chk("lone_regrant", 32'(in_ready), 32'b0100);
      step();

      // Backpressure: fill slot with 7 from requester 3, then stall.
      in0 = 4'h1; in1 = 4'h2; in3 = 4'h7; in_valid = 4'b1000;
      step();
      chk("bp_fill_data", 32'(out_data), 32'h7);
      in_valid = 4'b1111; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ready_low", 32'(in_ready),  32'h0);
         chk("bp_hold_data", 32'(out_data),  32'h7);
         chk("bp_hold_src",  32'(out_src),   32'h3);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 32'b0001);
      step();
      chk("bp_refill_data",  32'(out_data),  32'h1);
      chk("bp_refill_valid", 32'(out_valid), 32'h1);

      // Fairness: requester 0 continuously valid, requester 3 joins once.
      in_valid = 4'b0001;
      step(); step();
      in_valid = 4'b1001;
      got3 = 0;
      for (int i = 0; i < 4 && !got3; i++) begin
         @(negedge clk);
         if (in_ready[3]) got3 = 1;
         step();
      end
      chk("fair_req3_granted", 32'(got3),    32'h1);
      chk("fair_req3_src",     32'(out_src), 32'h3);
      in_valid = 4'b0001;
      step();
      chk("fair_req0_resumes", 32'(out_src), 32'h0);

      // Reset while FULL, then a fresh grant to requester 1.
      rst = 1'b1; in_valid = 4'b0010;
      @(negedge clk);
      chk("midrst_ready", 32'(in_ready), 32'h0);
      step();
      rst = 1'b0; in_valid = 4'b0000;
      @(negedge clk);
      chk("midrst_valid", 32'(out_valid), 32'h0);
      chk("midrst_ptr0",  32'(sel),       32'h0);
      step();
      in_valid = 4'b0010;
      @(negedge clk);
      chk("midrst_ready1", 32'(in_ready), 32'b0010);
      step();
      chk("midrst_src",  32'(out_src),  32'h1);
      chk("midrst_data", 32'(out_data), 32'h2);
      in_valid = 4'b0000;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
